// File: rtl/pixel_fetch_if.sv
// Memory-side and stream-side signals of the pixel fetcher.
// The master modport is the fetcher; the slave modport is the memory and the video consumer.
interface pixel_fetch_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] addr;
    logic              bank;
    logic [2:0]        pix_sel;
    logic [3:0]        pixel_in;
    logic [3:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output addr, bank, pix_sel, pix_data, pix_valid,
        input  pixel_in, pix_ready
    );

    modport slave (
        input  addr, bank, pix_sel, pix_data, pix_valid,
        output pixel_in, pix_ready
    );
endinterface

// File: rtl/pixel_fetch.sv
// Line fetcher for the external pixel memory: issues one nibble read per cycle under a FIFO
// credit limit, buffers returns in a small FIFO and streams them out with valid/ready.
module pixel_fetch #(
    parameter int ADDR_W     = 9,
    parameter int LINE_PIX   = 64,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic [ADDR_W+2:0] start_pix,
    input  logic              frame_swap,
    pixel_fetch_if.master     bus,
    output logic              busy,
    output logic              underrun
);
    localparam int PIX_W  = ADDR_W + 3;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LCNT_W = $clog2(LINE_PIX + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state;
    logic [PIX_W-1:0]   next_pix;
    logic [LCNT_W-1:0]  issued;
    logic [MEM_LAT-1:0] pipe;
    logic [ADDR_W-1:0]  addr_q;
    logic [2:0]         sel_q;
    logic               bank_q;
    logic               swap_pending;

    logic [3:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic               pix_valid_i;
    logic               credit_ok;
    logic               issue;
    logic               fifo_wr;
    logic               fifo_rd;
    logic [MEM_LAT-1:0] pipe_next;

    // Credits count both buffered pixels and reads still in flight, so every return has a slot.
    assign credit_ok   = (int'(fifo_count) + $countones(pipe)) < FIFO_DEPTH;
    assign issue       = (state == FETCH) && credit_ok && !line_start;
    // A line_start discards whatever the pipe delivers in that same cycle (old line's data).
    assign fifo_wr     = pipe[MEM_LAT-1] && !line_start;
    assign pix_valid_i = (fifo_count != '0);
    assign fifo_rd     = pix_valid_i && bus.pix_ready && !line_start;
    assign pipe_next   = MEM_LAT'({pipe, issue});

    assign bus.addr      = addr_q;
    assign bus.pix_sel   = sel_q;
    assign bus.bank      = bank_q;
    assign bus.pix_valid = pix_valid_i;
    assign bus.pix_data  = pix_valid_i ? fifo_mem[rd_ptr] : 4'h0;

    assign busy     = (state != IDLE);
    assign underrun = busy && bus.pix_ready && !pix_valid_i;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge value of every other register regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            next_pix     <= '0;
            issued       <= '0;
            pipe         <= '0;
            addr_q       <= '0;
            sel_q        <= '0;
            bank_q       <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (line_start) begin
                bank_q       <= bank_q ^ swap_pending;
                swap_pending <= frame_swap;
            end else if (frame_swap) begin
                swap_pending <= 1'b1;
            end

            if (line_start) begin
                // The FIFO is flushed on this edge, so the first read always has credit.
                addr_q   <= start_pix[PIX_W-1:3];
                sel_q    <= start_pix[2:0];
                next_pix <= start_pix + 1'b1;
                issued   <= LCNT_W'(1);
                pipe     <= MEM_LAT'(1);
                state    <= (LINE_PIX == 1) ? DRAIN : FETCH;
            end else begin
                pipe <= pipe_next;
                case (state)
                    FETCH: begin
                        if (issue) begin
                            addr_q   <= next_pix[PIX_W-1:3];
                            sel_q    <= next_pix[2:0];
                            next_pix <= next_pix + 1'b1;
                            issued   <= issued + 1'b1;
                            if (issued == LCNT_W'(LINE_PIX - 1)) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (pipe_next == '0) begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (line_start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count define its contents, and
    // pix_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= bus.pixel_in;
        end
    end
endmodule
